// File: rtl/mem_responder.sv
// Memory-side responder for the 16-bit mem_* bus: word array target with
// programmable wait states, fixed read latency and sticky error flags.
module mem_responder #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned WAIT_STATES  = 1,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [19:0] mem_address,
   input  logic [1:0]  mem_byteenable,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_writedata,
   output logic        mem_waitrequest,
   output logic [15:0] mem_readdata,
   output logic        mem_readdataready,
   output logic        proto_err,
   output logic        range_err
);

   localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              w_req;
   logic              w_drop;
   logic              w_accept;
   logic              w_oor;
   logic              w_do_write;
   logic              w_rd_acc;
   logic [ADDR_W-1:0] w_idx;
   logic [15:0]       w_rd_word;

   logic [15:0]             r_mem [(1 << ADDR_W)];
   logic [READ_LATENCY-1:0] r_vld;
   logic [15:0]             r_dat [READ_LATENCY];
   logic                    r_proto_err;
   logic                    r_range_err;

   assign w_req = mem_read | mem_write;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      mem_waitrequest = 1'b0;
      w_drop          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req && (LP_WS != '0)) begin
               mem_waitrequest = 1'b1;
               w_state_nxt     = S_WAIT;
               w_cnt_nxt       = 4'd1;
            end
         end
         S_WAIT: begin
            if (!w_req) begin
               w_drop      = 1'b1;
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt < LP_WS) begin
               mem_waitrequest = 1'b1;
               w_cnt_nxt       = r_cnt + 4'd1;
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      if (reset) begin
         mem_waitrequest = 1'b1;
      end
   end

   assign w_accept   = w_req & ~mem_waitrequest;
   assign w_oor      = (mem_address >> ADDR_W) != '0;
   assign w_idx      = mem_address[ADDR_W-1:0];
   assign w_do_write = w_accept & mem_write & ~w_oor;
   // A simultaneous read+write is a protocol error: the write wins, the read is dropped.
   assign w_rd_acc   = w_accept & mem_read & ~mem_write;
   assign w_rd_word  = w_oor ? '0 : r_mem[w_idx];

   always_ff @(posedge clock) begin
      if (w_do_write) begin
         if (mem_byteenable[0]) r_mem[w_idx][7:0]  <= mem_writedata[7:0];
         if (mem_byteenable[1]) r_mem[w_idx][15:8] <= mem_writedata[15:8];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_vld       <= '0;
         r_proto_err <= 1'b0;
         r_range_err <= 1'b0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         // Data stages only load behind a valid bit, so the last stage holds between pulses.
         r_vld[0] <= w_rd_acc;
         if (w_rd_acc) r_dat[0] <= w_rd_word;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
         end
         if (w_drop || (w_accept && mem_read && mem_write)) r_proto_err <= 1'b1;
         if (w_accept && w_oor) r_range_err <= 1'b1;
      end
   end

   assign mem_readdataready = r_vld[READ_LATENCY-1];
   assign mem_readdata      = r_dat[READ_LATENCY-1];
   assign proto_err         = r_proto_err;
   assign range_err         = r_range_err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 uses default timing,
// instance 1 uses WAIT_STATES=0 / READ_LATENCY=3 for streaming.
module tb_mem_responder;

   localparam int unsigned RL0 = 2;
   localparam int unsigned RL1 = 3;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic [19:0] addr  [2];
   logic [1:0]  be    [2];
   logic        rd    [2];
   logic        wr    [2];
   logic [15:0] wd    [2];
   logic        wreq  [2];
   logic [15:0] rdata [2];
   logic        rdy   [2];
   logic        perr  [2];
   logic        rerr  [2];

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(10), .WAIT_STATES(1), .READ_LATENCY(RL0)) u_dut0 (
      .clock(clk), .reset(rst[0]), .mem_address(addr[0]), .mem_byteenable(be[0]),
      .mem_read(rd[0]), .mem_write(wr[0]), .mem_writedata(wd[0]),
      .mem_waitrequest(wreq[0]), .mem_readdata(rdata[0]), .mem_readdataready(rdy[0]),
      .proto_err(perr[0]), .range_err(rerr[0]));

   mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .READ_LATENCY(RL1)) u_dut1 (
      .clock(clk), .reset(rst[1]), .mem_address(addr[1]), .mem_byteenable(be[1]),
      .mem_read(rd[1]), .mem_write(wr[1]), .mem_writedata(wd[1]),
      .mem_waitrequest(wreq[1]), .mem_readdata(rdata[1]), .mem_readdataready(rdy[1]),
      .proto_err(perr[1]), .range_err(rerr[1]));

   typedef struct packed {
      logic [15:0] d;
      logic [31:0] due;
   } sb_t;

   sb_t         q0[$];
   sb_t         q1[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cyc      = '0;
   logic [15:0] last0    = '0;
   logic [15:0] last1    = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst[0]) begin
         last0 = '0;
      end else if (rdy[0]) begin
         if (q0.size() == 0) begin
            check("u0_unexpected_pulse", 32'(rdy[0]), 32'd0);
         end else begin
            sb_t e;
            e = q0.pop_front();
            check("u0_rdata", 32'(rdata[0]), 32'(e.d));
            check("u0_latency", cyc, e.due);
         end
         last0 = rdata[0];
      end else begin
         check("u0_hold", 32'(rdata[0]), 32'(last0));
      end
   end

   always @(negedge clk) begin
      if (rst[1]) begin
         last1 = '0;
      end else if (rdy[1]) begin
         if (q1.size() == 0) begin
            check("u1_unexpected_pulse", 32'(rdy[1]), 32'd0);
         end else begin
            sb_t e;
            e = q1.pop_front();
            check("u1_rdata", 32'(rdata[1]), 32'(e.d));
            check("u1_latency", cyc, e.due);
         end
         last1 = rdata[1];
      end else begin
         check("u1_hold", 32'(rdata[1]), 32'(last1));
      end
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic do_cmd(input int s, input logic r, input logic w, input logic [19:0] a,
                         input logic [1:0] b, input logic [15:0] d, input int exp_wait,
                         input logic push, input logic [15:0] exp_d);
      int   waits;
      logic ok;
      sb_t  e;
      waits = 0;
      ok    = 1'b0;
      rd[s] = r; wr[s] = w; addr[s] = a; be[s] = b; wd[s] = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!wreq[s]) begin
            ok = 1'b1;
            break;
         end
         waits++;
      end
      check($sformatf("u%0d_accept_seen_a%0h", s, a), 32'(ok), 32'd1);
      check($sformatf("u%0d_waits_a%0h", s, a), 32'(waits), 32'(exp_wait));
      if (push) begin
         e.d   = exp_d;
         e.due = cyc + ((s == 0) ? RL0 : RL1);
         if (s == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(posedge clk);
      #1;
      rd[s] = 1'b0;
      wr[s] = 1'b0;
   endtask

   task automatic drop_read(input logic [19:0] a);
      rd[0]   = 1'b1;
      addr[0] = a;
      @(negedge clk);
      check("drop_wait_high", 32'(wreq[0]), 32'd1);
      @(posedge clk);
      #1;
      rd[0] = 1'b0;
      @(negedge clk);
      check("drop_wait_low_idle", 32'(wreq[0]), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b1; rd[s] = 1'b0; wr[s] = 1'b0;
         addr[s] = '0; be[s] = '0; wd[s] = '0;
      end
      @(negedge clk);
      #1;
      check("rst_wait0", 32'(wreq[0]), 32'd1);
      check("rst_wait1", 32'(wreq[1]), 32'd1);
      check("rst_rdy", 32'(rdy[0]), 32'd0);
      check("rst_rdata", 32'(rdata[0]), 32'd0);
      check("rst_perr", 32'(perr[0]), 32'd0);
      check("rst_rerr", 32'(rerr[0]), 32'd0);
      @(negedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk);
      #1;

      do_cmd(0, 1'b0, 1'b1, 20'd5, 2'b11, 16'hA55A, 1, 1'b0, '0);
      do_cmd(0, 1'b1, 1'b0, 20'd5, 2'b11, 16'h0000, 1, 1'b1, 16'hA55A);

      do_cmd(0, 1'b0, 1'b1, 20'd7, 2'b11, 16'h1234, 1, 1'b0, '0);
      do_cmd(0, 1'b0, 1'b1, 20'd7, 2'b10, 16'hFF00, 1, 1'b0, '0);
      do_cmd(0, 1'b0, 1'b1, 20'd7, 2'b01, 16'h00CD, 1, 1'b0, '0);
      do_cmd(0, 1'b0, 1'b1, 20'd8, 2'b00, 16'hFFFF, 1, 1'b0, '0);
      do_cmd(0, 1'b1, 1'b0, 20'd7, 2'b00, 16'h0000, 1, 1'b1, 16'hFFCD);

      for (int i = 0; i < 8; i++)
         do_cmd(1, 1'b0, 1'b1, 20'(i), 2'b11, 16'h100 + 16'(i), 0, 1'b0, '0);
      for (int i = 0; i < 8; i++)
         do_cmd(1, 1'b1, 1'b0, 20'(i), 2'b01, 16'h0000, 0, 1'b1, 16'h100 + 16'(i));

      check("range_pre", 32'(rerr[0]), 32'd0);
      do_cmd(0, 1'b1, 1'b0, 20'h00400, 2'b11, 16'h0000, 1, 1'b1, 16'h0000);
      check("range_set", 32'(rerr[0]), 32'd1);
      check("perr_pre", 32'(perr[0]), 32'd0);
      do_cmd(0, 1'b1, 1'b1, 20'd9, 2'b11, 16'hBEEF, 1, 1'b0, '0);
      check("perr_rdwr", 32'(perr[0]), 32'd1);
      do_cmd(0, 1'b1, 1'b0, 20'd9, 2'b11, 16'h0000, 1, 1'b1, 16'hBEEF);
      drop_read(20'd3);
      do_cmd(0, 1'b1, 1'b0, 20'd5, 2'b11, 16'h0000, 1, 1'b1, 16'hA55A);
      repeat (6) @(posedge clk);
      #1;

      do_cmd(0, 1'b1, 1'b0, 20'd7, 2'b11, 16'h0000, 1, 1'b0, '0);
      @(negedge clk);
      #1;
      rst[0] = 1'b1;
      #1;
      check("midrst_wait", 32'(wreq[0]), 32'd1);
      check("midrst_rdy", 32'(rdy[0]), 32'd0);
      check("midrst_rdata", 32'(rdata[0]), 32'd0);
      check("midrst_perr", 32'(perr[0]), 32'd0);
      check("midrst_rerr", 32'(rerr[0]), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      rst[0] = 1'b0;
      @(posedge clk);
      #1;
      do_cmd(0, 1'b1, 1'b0, 20'd5, 2'b11, 16'h0000, 1, 1'b1, 16'hA55A);

      check("perr_pre_drop", 32'(perr[0]), 32'd0);
      drop_read(20'd3);
      check("perr_drop", 32'(perr[0]), 32'd1);
      check("rerr_after_drop", 32'(rerr[0]), 32'd0);
      do_cmd(0, 1'b1, 1'b0, 20'd7, 2'b11, 16'h0000, 1, 1'b1, 16'hFFCD);

      repeat (8) @(posedge clk);
      #1;
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable memory-side responder for the 16-bit `mem_*` bus that `mem_if` drives as initiator. It answers reads and writes from an internal word array with a programmable number of wait states and a fixed read latency, and flags protocol and address-range errors. It stands in for the SRAM arbiter plus SRAM in FPGA self-test builds and gives the bus initiator a cycle-exact, repeatable target in simulation.

## Interface
- `ADDR_W`, 10: internal array depth is 2^ADDR_W 16-bit words.
- `WAIT_STATES`, 1: number of cycles `mem_waitrequest` is held high before a command is accepted. Legal range is 0..15.
- `READ_LATENCY`, 2: number of cycles from the accept edge to `mem_readdataready`. Legal range is 1..8.
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_address`  in  20  word address.
- `mem_byteenable`  in  2  bit 0 enables [7:0], bit 1 enables [15:8].
- `mem_read`  in  1  read request.
- `mem_write`  in  1  write request.
- `mem_writedata`  in  16  write data.
- `mem_waitrequest`  out  1  command is not accepted this cycle.
- `mem_readdata`  out  16  read data, valid while `mem_readdataready` is high.
- `mem_readdataready`  out  1  one-cycle pulse per accepted read.
- `proto_err`  out  1  sticky flag for a protocol violation.
- `range_err`  out  1  sticky flag for an access outside the array.

## Operation
- A request is any cycle with `mem_read | mem_write` high. A command is accepted on a rising edge where a request is present and `mem_waitrequest` is low. Address, byteenable and data are sampled only on the accept edge.
- The state machine has two states, IDLE and WAIT, with a 4-bit counter `cnt`.
  - IDLE with a request and WAIT_STATES=0: waitrequest is low and the command is accepted; stay in IDLE.
  - IDLE with a request and WAIT_STATES>0: waitrequest is high; go to WAIT with cnt=1.
  - WAIT with cnt<WAIT_STATES: waitrequest is high and cnt increments.
  - WAIT with cnt==WAIT_STATES: waitrequest is low, the command is accepted, and the FSM returns to IDLE.
  - WAIT with the request dropped: set `proto_err` and return to IDLE; nothing is accepted.
- `mem_waitrequest` is combinational from state, `cnt`, the request and `reset`. It is forced high while `reset` is high and is low in IDLE when there is no request.
- Write accept: for each enabled byte lane, update `array[mem_address[ADDR_W-1:0]]`. With byteenable=00 the write is a no-op with no error.
- Read accept: `array` is read on the accept edge. A write accepted on an earlier edge is visible to it. The data enters a READ_LATENCY-deep valid/data shift pipeline. Byteenable does not mask readdata; all 16 bits are returned.
- Read and write both high in the same request: the write is performed, the read is dropped, and `proto_err` is set.
- Address bits [19:ADDR_W] nonzero on accept: the write is dropped; a read returns 16'h0000 but still pulses `mem_readdataready`. `range_err` is set in both cases.
- Both error flags clear only on reset.

## Timing
- Accept rate: one command per WAIT_STATES+1 cycles of continuous requests, so back-to-back every cycle when WAIT_STATES=0.
- A read accepted at edge N drives `mem_readdataready`=1 and `mem_readdata` during the cycle after edge N+READ_LATENCY-1, i.e. after READ_LATENCY edges. Pulses are ordered and never merge; reads accepted back-to-back produce back-to-back pulses.
- Between pulses, `mem_readdata` holds its last value.
- New commands are accepted while earlier reads are still in flight; no stall.
- Reset values: `mem_readdataready`=0, `mem_readdata`=16'h0000, `proto_err`=0, `range_err`=0, FSM=IDLE, `cnt`=0, pipeline valid bits all 0, `mem_waitrequest`=1 while reset is asserted.
- Reset mid-operation: in-flight reads are discarded with no pulse, and a pending wait is abandoned. The array is not reset and keeps its contents.

## Test plan
- Write/read, defaults: write 16'hA55A to addr 5 with be=11, then read addr 5. Required: waitrequest high for 1 cycle on each command, and readdataready pulses exactly 2 edges after the read accept with data 16'hA55A.
- Byte lanes: write 16'h1234 to addr 7 with be=11, then 16'hFF00 with be=10, then 16'h00CD with be=01, then read addr 7. Required: data 16'hFFCD.
- Streaming at WAIT_STATES=0, READ_LATENCY=3: 8 consecutive reads of addr 0..7 preloaded with 16'h100+i. Required: waitrequest stays low, and 8 contiguous pulses return 16'h100..16'h107 in order starting 3 edges after the first accept.
- Errors: read of addr 20'h00400 with ADDR_W=10. Required: data 16'h0000 with a pulse, and `range_err`=1. Then read and write both high on one request. Required: write done, no read pulse, `proto_err`=1. Then drop read while waitrequest is high. Required: no pulse and FSM back in IDLE.
- Reset mid-flight: assert reset 1 cycle after a read accept. Required: no readdataready pulse, `mem_readdata`=0, error flags 0. Then a read of an address written before the reset returns the pre-reset data.
